mdl_disp_mux_n: RTL and testbench
=================================

MDL_DISP_MUX_N -- requirements
Module: mdl_disp_mux_n

Interface
REQ-001 SHALL have parameter DIGITS, default 4, number of multiplexed digits (legal 1..8).
REQ-002 SHALL have parameter DIV_W, default 16, log2 of clocks per digit slot (legal 6..24).
REQ-003 SHALL have parameter DEAD, default 4, anti-ghost blank clocks at slot start (legal 1..2^(DIV_W-4)-1).
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port reset_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port din  input  8*DIGITS  per-digit raw segment patterns (active-low), digit k at [8k+7:8k].
REQ-007 SHALL have port blank  input  DIGITS  per-digit blank mask, 1 = digit dark.
REQ-008 SHALL have port bright  input  4  brightness level, 0 = dark, 15 = full.
REQ-009 SHALL have port an  output  DIGITS  active-low anode enables, registered.
REQ-010 SHALL have port sseg  output  8  active-low segment pattern, registered.
REQ-011 SHALL have port frame_tick  output  1  one-clock pulse at start of each frame, registered.

Function
REQ-012 SHALL run a DIV_W-bit slot counter cnt incrementing every clock, wrapping 2^DIV_W-1 -> 0.
REQ-013 SHALL advance digit index idx by one when cnt wraps, wrapping DIGITS-1 -> 0 (non-power-of-two DIGITS exact, no skipped or extra slots).
REQ-014 SHALL capture din and blank into snapshot registers on the clock where cnt==0 and idx==0; mid-frame input changes are invisible until next frame.
REQ-015 SHALL compute digit-on = (cnt >= DEAD) AND NOT snapshot_blank[idx] AND pwm_on.
REQ-016 SHALL define pwm_on = 1 when bright==15, else (cnt[DIV_W-1:DIV_W-4] < bright).
REQ-017 SHALL register outputs: one clock after state (cnt, idx), an = digit-on ? ~(1<<idx) : all ones; sseg = digit-on ? snapshot_din[idx] : 8'hFF.
REQ-018 SHALL never assert more than one anode in any cycle, including idx wrap and parameter extremes.
REQ-019 SHALL pulse frame_tick high for exactly one clock, one clock after cnt==0 and idx==0.
REQ-020 SHALL, with DIGITS==1, hold idx at 0 and pulse frame_tick every 2^DIV_W clocks.
REQ-021 SHALL treat bright changes immediately (no snapshot); a change mid-slot affects only remaining clocks of that slot.

Reset
REQ-022 SHALL on reset_n low asynchronously set cnt=0, idx=0, snapshot_din all 8'hFF, snapshot_blank all ones, an all ones, sseg=8'hFF, frame_tick=0.
REQ-023 SHALL on reset_n release start with cnt=0, idx=0, so first post-reset clock captures the snapshot and produces frame_tick next clock.
REQ-024 SHALL on reset asserted mid-slot blank the display within the same cycle (asynchronous), no partial pattern held.

Configuration
REQ-025 SHALL compile brightness PWM only when macro DISP_MUX_PWM_EN is defined; then REQ-016 applies.
REQ-026 SHALL, with DISP_MUX_PWM_EN undefined, force pwm_on=1, keep port bright present but ignored, and add no PWM logic.

Structure
REQ-027 SHALL take constants SEG_OFF (8'hFF), MAX_DIGITS (8) and BRIGHT_FULL (4'hF) from shared package disp_pkg.
REQ-028 SHALL place cnt/idx/frame-start generation in sub-module mdl_disp_scan (parameters DIGITS, DIV_W; outputs cnt, idx, frame_start).
REQ-029 SHALL keep snapshot, gating and output registers in mdl_disp_mux_n.

Verification (DIGITS=3, DIV_W=6, DEAD=2, PWM enabled unless stated)
REQ-030 SHALL check scan: din={8'hC0,8'hF9,8'hA4}, blank=0, bright=15 -> an cycles 110,101,011 each on 62 of 64 clocks, sseg matches digit, slots 64 clocks, idx 2->0 wrap.
REQ-031 SHALL check PWM: bright=8 -> each digit on exactly 30 clocks per slot (cnt 2..31); bright=0 -> an all ones for full frame.
REQ-032 SHALL check snapshot: change din mid-frame 1 -> old pattern until frame_tick, new pattern from next digit-0 slot; blank=3'b010 -> digit 1 dark, an never 101.
REQ-033 SHALL check reset: reset_n low at cnt=37, idx=1 -> an=111, sseg=FF same cycle; release -> frame_tick one clock after first post-reset clock, then every 192 clocks.
REQ-034 SHALL check one-hot safety: random din/blank/bright for 10000 clocks -> an never has two zero bits; rebuild without DISP_MUX_PWM_EN, bright=0 -> digits on 62 of 64 clocks.

Source files
------------

// File: rtl/disp_pkg.sv
// Shared constants for the multiplexed seven-segment display family.
// Latency: none (constants and an elaboration-time helper only).
// Backpressure: not applicable.
package disp_pkg;

    localparam logic [7:0] SEG_OFF     = 8'hFF;
    localparam int         MAX_DIGITS  = 8;
    localparam logic [3:0] BRIGHT_FULL = 4'hF;

    // Width of the digit index; a single-digit display still needs one bit.
    function automatic int idx_width(input int digits);
        int d;
        d = (digits > MAX_DIGITS) ? MAX_DIGITS : digits;
        return (d > 1) ? $clog2(d) : 1;
    endfunction

endpackage

// File: rtl/mdl_disp_scan.sv
// Slot counter and digit index generator for the display multiplexer.
// Latency: frame_start is combinational from the registered cnt/idx state.
// Backpressure: none, free-running from reset release.
module mdl_disp_scan
    import disp_pkg::*;
#(
    parameter int DIGITS = 4,
    parameter int DIV_W  = 16,
    localparam int IDX_W = idx_width(DIGITS)
) (
    input  logic             clk,
    input  logic             reset_n,
    output logic [DIV_W-1:0] cnt,
    output logic [IDX_W-1:0] idx,
    output logic             frame_start
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
            idx <= '0;
        end else begin
            cnt <= cnt + 1'b1;
            // Explicit wrap keeps non-power-of-two digit counts exact.
            if (&cnt) begin
                idx <= (idx == IDX_W'(DIGITS - 1)) ? '0 : idx + 1'b1;
            end
        end
    end

    assign frame_start = (cnt == '0) && (idx == '0);

endmodule

// File: rtl/mdl_disp_mux_n.sv
// N-digit display multiplexer with frame snapshot, anti-ghost dead time and optional PWM (DISP_MUX_PWM_EN).
// Latency: an/sseg/frame_tick registered one clock after the scan state.
// Backpressure: none; din/blank sampled once per frame, bright used live.
module mdl_disp_mux_n
    import disp_pkg::*;
#(
    parameter int DIGITS = 4,
    parameter int DIV_W  = 16,
    parameter int DEAD   = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [8*DIGITS-1:0]   din,
    input  logic [DIGITS-1:0]     blank,
    input  logic [3:0]            bright,
    output logic [DIGITS-1:0]     an,
    output logic [7:0]            sseg,
    output logic                  frame_tick
);

    localparam int IDX_W = idx_width(DIGITS);

    logic [DIV_W-1:0]    cnt;
    logic [IDX_W-1:0]    idx;
    logic                frame_start;
    logic [8*DIGITS-1:0] snap_din;
    logic [DIGITS-1:0]   snap_blank;
    logic                pwm_on;
    logic                past_dead;
    logic                digit_on;
    logic [DIGITS-1:0]   an_nxt;
    logic [7:0]          seg_nxt;

    mdl_disp_scan #(
        .DIGITS (DIGITS),
        .DIV_W  (DIV_W)
    ) u_scan (
        .clk         (clk),
        .reset_n     (reset_n),
        .cnt         (cnt),
        .idx         (idx),
        .frame_start (frame_start)
    );

`ifdef DISP_MUX_PWM_EN
    assign pwm_on = (bright == BRIGHT_FULL) || (cnt[DIV_W-1 -: 4] < bright);
`else
    logic unused_bright;
    assign unused_bright = ^bright;
    assign pwm_on        = 1'b1;
`endif

    assign past_dead = (cnt >= DIV_W'(DEAD));

    // Anode bits are decoded per digit against idx, so at most one can go low.
    always_comb begin
        digit_on = 1'b0;
        an_nxt   = '1;
        seg_nxt  = SEG_OFF;
        for (int k = 0; k < DIGITS; k++) begin
            if (idx == IDX_W'(k)) begin
                digit_on  = past_dead && !snap_blank[k] && pwm_on;
                an_nxt[k] = !digit_on;
                seg_nxt   = digit_on ? snap_din[8*k +: 8] : SEG_OFF;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            snap_din   <= {DIGITS{SEG_OFF}};
            snap_blank <= '1;
            an         <= '1;
            sseg       <= SEG_OFF;
            frame_tick <= 1'b0;
        end else begin
            if (frame_start) begin
                snap_din   <= din;
                snap_blank <= blank;
            end
            an         <= an_nxt;
            sseg       <= seg_nxt;
            frame_tick <= frame_start;
        end
    end

endmodule

// File: tb/tb_mdl_disp_mux_n.sv
// Bench for mdl_disp_mux_n at DIGITS=3, DIV_W=6, DEAD=2; PWM expectations follow DISP_MUX_PWM_EN.
module tb_mdl_disp_mux_n;

    localparam int DIGITS = 3;
    localparam int DIV_W  = 6;
    localparam int DEAD   = 2;
    localparam int SLOT   = 64;
    localparam int FRAME  = SLOT * DIGITS;
`ifdef DISP_MUX_PWM_EN
    localparam bit PWM = 1'b1;
`else
    localparam bit PWM = 1'b0;
`endif
    localparam int ON_FULL = SLOT - DEAD;
    localparam int ON_B8   = PWM ? 30 : 62;
    localparam int ON_B0   = PWM ? 0 : 62;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic [23:0] din = 24'hFFFFFF;
    logic [2:0]  blank = 3'b000;
    logic [3:0]  bright = 4'd15;
    logic [2:0]  an;
    logic [7:0]  sseg;
    logic        frame_tick;
    logic        chk_en = 1'b0;

    int total = 0;
    int bad   = 0;

    mdl_disp_mux_n #(
        .DIGITS (DIGITS),
        .DIV_W  (DIV_W),
        .DEAD   (DEAD)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .din        (din),
        .blank      (blank),
        .bright     (bright),
        .an         (an),
        .sseg       (sseg),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: time since reset release decides slot and position directly.
    function automatic bit lit(input int pos, input logic [3:0] b);
        if (!PWM) return 1'b1;
        return (b == 4'd15) || (pos < 4 * int'(b));
    endfunction

    function automatic bit on_at(input int unsigned t, input logic [2:0] bl, input logic [3:0] b);
        int pos;
        int slot;
        pos  = int'(t % SLOT);
        slot = int'((t / SLOT) % DIGITS);
        return (pos >= DEAD) && !bl[slot] && lit(pos, b);
    endfunction

    function automatic int slot_of(input int unsigned t);
        return int'((t / SLOT) % DIGITS);
    endfunction

    int unsigned m;
    logic [23:0] m_din;
    logic [2:0]  m_blank;
    logic [2:0]  exp_an;
    logic [7:0]  exp_sseg;
    logic        exp_tick;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m        <= 0;
            m_din    <= 24'hFFFFFF;
            m_blank  <= 3'b111;
            exp_an   <= 3'b111;
            exp_sseg <= 8'hFF;
            exp_tick <= 1'b0;
        end else begin
            m <= m + 1;
            if (m % FRAME == 0) begin
                m_din   <= din;
                m_blank <= blank;
            end
            exp_tick <= (m % FRAME == 0);
            exp_an   <= on_at(m, m_blank, bright) ? ~(3'b001 << slot_of(m)) : 3'b111;
            exp_sseg <= on_at(m, m_blank, bright) ? m_din[8*slot_of(m) +: 8] : 8'hFF;
        end
    end

    function automatic bit hit(input logic [2:0] a, input int k);
        return a == ~(3'b001 << k);
    endfunction

    int         on_acc [3];
    int         last_on [3];
    int         period_acc = 0;
    int         last_period = 0;
    logic [7:0] seg_seen [3];

    always @(negedge clk) begin
        if (chk_en) begin
            check("an", 32'(an), 32'(exp_an));
            check("sseg", 32'(sseg), 32'(exp_sseg));
            check("frame_tick", 32'(frame_tick), 32'(exp_tick));
            check("one_hot", 32'($countones(~an) <= 1), 32'd1);
        end
        for (int k = 0; k < DIGITS; k++) begin
            if (frame_tick) begin
                last_on[k] <= on_acc[k];
                on_acc[k]  <= int'(hit(an, k));
            end else begin
                on_acc[k] <= on_acc[k] + int'(hit(an, k));
            end
            if (hit(an, k)) seg_seen[k] <= sseg;
        end
        if (frame_tick) begin
            last_period <= period_acc;
            period_acc  <= 1;
        end else begin
            period_acc <= period_acc + 1;
        end
    end

    // Returns just after the negedge where frame_tick is seen, counters settled.
    task automatic wait_tick();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_tick && n < FRAME + 50);
        check("tick_seen", 32'(frame_tick), 32'd1);
        #1;
    endtask

    task automatic check_on(input string name, input int e0, input int e1, input int e2);
        check({name, "_d0"}, 32'(last_on[0]), 32'(e0));
        check({name, "_d1"}, 32'(last_on[1]), 32'(e1));
        check({name, "_d2"}, 32'(last_on[2]), 32'(e2));
    endtask

    task automatic check_seg(input string name, input logic [23:0] e);
        check({name, "_d0"}, 32'(seg_seen[0]), 32'(e[7:0]));
        check({name, "_d1"}, 32'(seg_seen[1]), 32'(e[15:8]));
        check({name, "_d2"}, 32'(seg_seen[2]), 32'(e[23:16]));
    endtask

    initial begin
        for (int k = 0; k < DIGITS; k++) begin
            on_acc[k]   = 0;
            last_on[k]  = 0;
            seg_seen[k] = 8'h00;
        end
        #1 reset_n = 1'b0;
        din    = {8'hC0, 8'hF9, 8'hA4};
        blank  = 3'b000;
        bright = 4'd15;
        repeat (3) @(negedge clk);
        check("rst_an", 32'(an), 32'h7);
        check("rst_sseg", 32'(sseg), 32'hFF);
        check("rst_tick", 32'(frame_tick), 32'h0);
        chk_en = 1'b1;
        #1 reset_n = 1'b1;

        @(negedge clk);
        check("first_tick", 32'(frame_tick), 32'h1);
        wait_tick();
        check_on("scan_on", ON_FULL, ON_FULL, ON_FULL);
        check_seg("scan_seg", 24'hC0F9A4);
        check("scan_period", 32'(last_period), 32'(FRAME));

        bright = 4'd8;
        wait_tick();
        check_on("pwm8_on", ON_B8, ON_B8, ON_B8);
        bright = 4'd0;
        wait_tick();
        check_on("pwm0_on", ON_B0, ON_B0, ON_B0);
        bright = 4'd15;

        repeat (84) @(negedge clk);
        #1 din = {8'h92, 8'h99, 8'hB0};
        wait_tick();
        check_seg("snap_old", 24'hC0F9A4);
        wait_tick();
        check_seg("snap_new", 24'h9299B0);

        blank = 3'b010;
        wait_tick();
        wait_tick();
        check_on("blank_on", ON_FULL, 0, ON_FULL);
        blank = 3'b000;
        wait_tick();

        repeat (100) @(negedge clk);
        check("pre_rst_an", 32'(an), 32'h5);
        #2 reset_n = 1'b0;
        #1;
        check("mid_rst_an", 32'(an), 32'h7);
        check("mid_rst_sseg", 32'(sseg), 32'hFF);
        repeat (3) @(negedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        check("post_rst_tick", 32'(frame_tick), 32'h1);
        wait_tick();
        check("post_rst_period", 32'(last_period), 32'(FRAME));

        repeat (10000) begin
            @(negedge clk);
            #1;
            din    = 24'($urandom);
            blank  = 3'($urandom);
            bright = 4'($urandom);
        end
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
